// File: rtl/pong_game_ctrl.sv
// Pong round/score sequencer: serve, play, point pause and game over, paced by frame ticks.
// Optional PAUSE state when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_load,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               winner,
  output logic               led
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4,
    PAUSE    = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  state_t             state_q, state_n;
  logic [7:0]         fcnt_q, fcnt_n, fcnt_inc;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic               btn_start_q, start_edge;
  logic               serve_dir_n, winner_n, led_n;
  logic               ball_load_n, ball_run_n;

  assign start_edge = btn_start & ~btn_start_q;
  assign fcnt_inc   = fcnt_q + 8'd1;
  assign state      = state_q;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fcnt_q      <= 8'd0;
      score_l     <= '0;
      score_r     <= '0;
      serve_dir   <= 1'b1;
      winner      <= 1'b0;
      led         <= 1'b0;
      ball_load   <= 1'b0;
      ball_run    <= 1'b0;
      btn_start_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      fcnt_q      <= fcnt_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      serve_dir   <= serve_dir_n;
      winner      <= winner_n;
      led         <= led_n;
      ball_load   <= ball_load_n;
      ball_run    <= ball_run_n;
      btn_start_q <= btn_start;
    end
  end

  always_comb begin
    state_n     = state_q;
    fcnt_n      = fcnt_q;
    score_l_n   = score_l;
    score_r_n   = score_r;
    serve_dir_n = serve_dir;
    winner_n    = winner;
    led_n       = led;
    if (enable) begin
      if (frame_tick && state_q != PAUSE)
        fcnt_n = fcnt_inc;
      case (state_q)
        IDLE: begin
          score_l_n = '0;
          score_r_n = '0;
          led_n     = 1'b0;
          if (start_edge) begin
            state_n     = SERVE;
            serve_dir_n = 1'b1;
          end
        end
        SERVE: begin
          if (frame_tick && fcnt_inc == SERVE_CNT)
            state_n = PLAY;
        end
        PLAY: begin
          unique case (1'b1)
            miss_left & miss_right: begin
              serve_dir_n = ~serve_dir;
              state_n     = POINT;
            end
            miss_left & ~miss_right: begin
              if (score_r != WIN) score_r_n = score_r + ONE;
              serve_dir_n = 1'b0;
              state_n     = POINT;
            end
            ~miss_left & miss_right: begin
              if (score_l != WIN) score_l_n = score_l + ONE;
              serve_dir_n = 1'b1;
              state_n     = POINT;
            end
            default: begin
`ifdef PONG_PAUSE_EN
              if (start_edge) state_n = PAUSE;
`endif
            end
          endcase
        end
        POINT: begin
          if (frame_tick && fcnt_inc == POINT_CNT) begin
            if (score_l == WIN) begin
              state_n  = GAMEOVER;
              winner_n = 1'b0;
            end else if (score_r == WIN) begin
              state_n  = GAMEOVER;
              winner_n = 1'b1;
            end else begin
              state_n = SERVE;
            end
          end
        end
        GAMEOVER: begin
          // Blink period: toggle on every 32nd frame since entry
          if (frame_tick && fcnt_inc[4:0] == 5'd0)
            led_n = ~led;
          if (start_edge) begin
            state_n   = IDLE;
            score_l_n = '0;
            score_r_n = '0;
            led_n     = 1'b0;
          end
        end
`ifdef PONG_PAUSE_EN
        PAUSE: begin
          if (start_edge) state_n = PLAY;
        end
`endif
        default: state_n = IDLE;
      endcase
      if (state_n != state_q)
        fcnt_n = 8'd0;
    end
    ball_load_n = enable && state_n == SERVE && state_q != SERVE;
    ball_run_n  = enable && state_n == PLAY;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_load, ball_run, serve_dir, winner, led;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .CLK100MHZ (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .frame_tick(frame_tick),
    .btn_start (btn_start),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .ball_load (ball_load),
    .ball_run  (ball_run),
    .serve_dir (serve_dir),
    .score_l   (score_l),
    .score_r   (score_r),
    .state     (state),
    .winner    (winner),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin errors++; $display("FAIL rst_scores got %0d/%0d want 0/0", score_l, score_r); end
    checks++; if ({ball_load, ball_run, serve_dir, winner, led} !== 5'b00100) begin
      errors++; $display("FAIL rst_outs got %b want 00100", {ball_load, ball_run, serve_dir, winner, led}); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_serve();
    enable = 1'b1;
    btn_start = 1'b1;
    step();
    checks++; if (state !== 3'd1 || ball_load !== 1'b1) begin errors++; $display("FAIL serve_entry got st=%0d ld=%b want 1/1", state, ball_load); end
    step();
    checks++; if (ball_load !== 1'b0) begin errors++; $display("FAIL serve_load_pulse got %b want 0", ball_load); end
    btn_start = 1'b0;
    tick(59);
    checks++; if (state !== 3'd1 || ball_run !== 1'b0) begin errors++; $display("FAIL serve_hold got st=%0d run=%b want 1/0", state, ball_run); end
    tick(1);
    checks++; if (state !== 3'd2 || ball_run !== 1'b1) begin errors++; $display("FAIL serve_to_play got st=%0d run=%b want 2/1", state, ball_run); end
  endtask

  task automatic test_miss_left();
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++; if (score_r !== 4'd1 || serve_dir !== 1'b0) begin errors++; $display("FAIL missl_score got r=%0d dir=%b want 1/0", score_r, serve_dir); end
    checks++; if (state !== 3'd3 || ball_run !== 1'b0) begin errors++; $display("FAIL missl_state got st=%0d run=%b want 3/0", state, ball_run); end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    step();
    checks++; if (score_r !== 4'd1 || state !== 3'd3) begin errors++; $display("FAIL miss_in_point got r=%0d st=%0d want 1/3", score_r, state); end
    tick(89);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL point_hold got %0d want 3", state); end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (state !== 3'd1 || ball_load !== 1'b1) begin errors++; $display("FAIL point_to_serve got st=%0d ld=%b want 1/1", state, ball_load); end
    step();
    checks++; if (ball_load !== 1'b0) begin errors++; $display("FAIL point_load_pulse got %b want 0", ball_load); end
    tick(60);
  endtask

  task automatic test_both_miss();
    miss_left = 1'b1;
    miss_right = 1'b1;
    step();
    miss_left = 1'b0;
    miss_right = 1'b0;
    checks++; if (score_l !== 4'd0 || score_r !== 4'd1) begin errors++; $display("FAIL both_scores got %0d/%0d want 0/1", score_l, score_r); end
    checks++; if (serve_dir !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL both_dir got dir=%b st=%0d want 1/3", serve_dir, state); end
    tick(90);
  endtask

  task automatic test_enable_freeze();
    tick(20);
    enable = 1'b0;
    tick(100);
    checks++; if (state !== 3'd1 || ball_run !== 1'b0) begin errors++; $display("FAIL frz_serve got st=%0d run=%b want 1/0", state, ball_run); end
    enable = 1'b1;
    tick(39);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL frz_remaining got %0d want 1", state); end
    tick(1);
    checks++; if (state !== 3'd2 || ball_run !== 1'b1) begin errors++; $display("FAIL frz_resume got st=%0d run=%b want 2/1", state, ball_run); end
    enable = 1'b0;
    step();
    checks++; if (ball_run !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL frz_play_run got run=%b st=%0d want 0/2", ball_run, state); end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    step();
    checks++; if (score_r !== 4'd1 || state !== 3'd2) begin errors++; $display("FAIL frz_miss got r=%0d st=%0d want 1/2", score_r, state); end
    enable = 1'b1;
    step();
    checks++; if (ball_run !== 1'b1) begin errors++; $display("FAIL frz_reenable got %b want 1", ball_run); end
  endtask

  task automatic test_start_in_play();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
`ifdef PONG_PAUSE_EN
    checks++; if (state !== 3'd5 || ball_run !== 1'b0) begin errors++; $display("FAIL pause_enter got st=%0d run=%b want 5/0", state, ball_run); end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    step();
    checks++; if (score_r !== 4'd1 || state !== 3'd5) begin errors++; $display("FAIL pause_miss got r=%0d st=%0d want 1/5", score_r, state); end
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    checks++; if (state !== 3'd2 || ball_run !== 1'b1) begin errors++; $display("FAIL pause_exit got st=%0d run=%b want 2/1", state, ball_run); end
`else
    checks++; if (state !== 3'd2 || ball_run !== 1'b1) begin errors++; $display("FAIL start_in_play got st=%0d run=%b want 2/1", state, ball_run); end
`endif
  endtask

  task automatic test_game_over();
    for (int i = 1; i <= 7; i++) begin
      miss_right = 1'b1;
      step();
      miss_right = 1'b0;
      checks++; if (score_l !== 4'(i) || state !== 3'd3) begin errors++; $display("FAIL win_score got l=%0d st=%0d want %0d/3", score_l, state, i); end
      if (i < 7) begin
        tick(90);
        tick(60);
      end
    end
    tick(90);
    checks++; if (state !== 3'd4 || winner !== 1'b0 || led !== 1'b0) begin
      errors++; $display("FAIL gameover got st=%0d win=%b led=%b want 4/0/0", state, winner, led); end
    tick(31);
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL led_31 got %b want 0", led); end
    tick(1);
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL led_32 got %b want 1", led); end
    tick(32);
    checks++; if (led !== 1'b0 || score_l !== 4'd7) begin errors++; $display("FAIL led_64 got led=%b l=%0d want 0/7", led, score_l); end
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    checks++; if (state !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0 || led !== 1'b0) begin
      errors++; $display("FAIL restart got st=%0d %0d/%0d led=%b want 0 0/0 0", state, score_l, score_r, led); end
    step();
  endtask

  task automatic test_reset_mid();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    tick(60);
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++; if (score_r !== 4'd1 || serve_dir !== 1'b0) begin errors++; $display("FAIL mid_pre got r=%0d dir=%b want 1/0", score_r, serve_dir); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || score_r !== 4'd0 || serve_dir !== 1'b1) begin
      errors++; $display("FAIL mid_async got st=%0d r=%0d dir=%b want 0/0/1", state, score_r, serve_dir); end
    step();
    reset_n = 1'b1;
    step();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_release got %0d want 0", state); end
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    checks++; if (state !== 3'd1 || ball_load !== 1'b1) begin errors++; $display("FAIL mid_restart got st=%0d ld=%b want 1/1", state, ball_load); end
    step();
  endtask

  initial begin
    test_reset();
    test_serve();
    test_miss_left();
    test_both_miss();
    test_enable_freeze();
    test_start_in_play();
    test_game_over();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Round/score sequencer for the Pong game. It sits between the debounced button inputs, the VGA frame timing, and the ball/paddle datapath. It decides when the ball is recentred, when it moves and which way it serves. It also keeps both scores and declares a winner. All timing is counted in video frames (`frame_tick`), so game pacing is independent of the 100 MHz system clock.

## Interface
Parameters:
- `WIN_SCORE`, 7: score that ends the game; must be ≤ 2^SCORE_W−1.
- `SCORE_W`, 4: score counter width.
- `SERVE_FRAMES`, 60: frames the ball is held centred before a serve; 1..255.
- `POINT_FRAMES`, 90: frames of post-point pause; 1..255.

Ports:
- `CLK100MHZ` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: game run enable; low = freeze.
- `frame_tick` in 1: one-cycle pulse per video frame, from VGA timing.
- `btn_start` in 1: debounced BTNC level; the block edge-detects it internally.
- `miss_left` in 1: one-cycle pulse when the ball passes the left paddle.
- `miss_right` in 1: one-cycle pulse when the ball passes the right paddle.
- `ball_load` out 1: one-cycle pulse; datapath recentres the ball.
- `ball_run` out 1: ball motion enable.
- `serve_dir` out 1: 0 = serve toward left, 1 = toward right.
- `score_l` out SCORE_W: left player score.
- `score_r` out SCORE_W: right player score.
- `state` out 3: current FSM state encoding.
- `winner` out 1: 0 = left, 1 = right; valid in GAMEOVER.
- `led` out 1: game-over blink indicator.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4, PAUSE=5 (PAUSE only with the macro).
- `start_edge` = `btn_start` & ~`btn_start_q`. The `btn_start_q` register updates every cycle, including while `enable` is low.
- 8-bit frame counter `fcnt`:
  - cleared on every state entry;
  - increments on `frame_tick` while `enable` is high.
- IDLE: scores held at 0, `ball_run`=0. `start_edge`&`enable` → SERVE with `ball_load` pulse, `serve_dir`=1.
- SERVE: `ball_run`=0. On the `frame_tick` that makes `fcnt`==SERVE_FRAMES → PLAY.
- PLAY: `ball_run`=1.
  - `miss_left` only → `score_r`+1, `serve_dir`=0, go to POINT.
  - `miss_right` only → `score_l`+1, `serve_dir`=1, go to POINT.
  - Both in the same cycle → no score change, `serve_dir` toggles, go to POINT.
- POINT: `ball_run`=0. On the `frame_tick` that makes `fcnt`==POINT_FRAMES:
  - if `score_l`==WIN_SCORE → GAMEOVER, `winner`=0;
  - else if `score_r`==WIN_SCORE → GAMEOVER, `winner`=1;
  - else → SERVE with `ball_load` pulse.
- GAMEOVER: `ball_run`=0, scores held. `led` toggles every 32 frame ticks. `start_edge` → IDLE, scores cleared, `led`=0.
- `enable` low, in any state:
  - state, scores and `fcnt` frozen;
  - `ball_run` forced 0;
  - misses and start edges ignored;
  - `ball_load` suppressed.
- Scores saturate at WIN_SCORE and never wrap.
- `miss_*` pulses outside PLAY are ignored.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `score_l`=`score_r`=0, `ball_load`=0, `ball_run`=0, `serve_dir`=1, `winner`=0, `led`=0, `fcnt`=0, `btn_start_q`=0.
- `reset_n` asserted mid-game returns every output to its reset value immediately (asynchronous). The first `start_edge` after deassertion requires a fresh 0→1 transition of `btn_start`.
- Miss on cycle N → updated score, `state`=POINT and `ball_run`=0 at N+1.
- `ball_load` is high for exactly the first cycle in which `state`=SERVE.
- SERVE lasts from entry to the SERVE_FRAMES-th subsequent `frame_tick`, +1 cycle. POINT likewise with POINT_FRAMES.
- `start_edge` on cycle N → state change visible at N+1.

## Configuration
- `PONG_PAUSE_EN` defined:
  - `start_edge` in PLAY → PAUSE; `ball_run`=0, `fcnt` and scores held.
  - `start_edge` in PAUSE → PLAY.
  - `miss_*` ignored in PAUSE.
- `PONG_PAUSE_EN` undefined:
  - `start_edge` in PLAY is ignored.
  - State 5 is unreachable; illegal encodings recover to IDLE.

## Test plan
- Reset, `enable`=1, raise `btn_start` → `state`=1 and `ball_load`=1 for one cycle. After 60 `frame_tick`s, `state`=2 and `ball_run`=1.
- In PLAY, pulse `miss_left` → next cycle `score_r`=1, `serve_dir`=0, `state`=3. After 90 ticks, `state`=1 with a `ball_load` pulse.
- Drive `miss_left` and `miss_right` in the same cycle → scores unchanged, `serve_dir` toggled, `state`=3.
- Score `score_l` to 7 → after POINT, `state`=4, `winner`=0, `led` toggles every 32 ticks. A `btn_start` edge → `state`=0, scores 0.
- Drop `enable` for 100 ticks during SERVE → `fcnt`/`state` frozen, `ball_run`=0. After re-enable, the serve completes after the remaining frame count.
- With `PONG_PAUSE_EN`: `start_edge` in PLAY → `state`=5, `ball_run`=0, a miss is ignored. A second edge → `state`=2. Without the macro, a `start_edge` in PLAY leaves `state`=2.
